uart_result_tx: RTL and testbench

Serial result-export block for the 16-bit pipelined CPU. It reads the store stream the memory stage produces (write strobe, 4-bit destination address, 16-bit data) and buffers each store in a small FIFO. Each store is sent over a UART line as a 3-byte 8N1 record, so a host can watch program results. It sits beside the memory stage, consumes writes without back-pressuring the pipeline, and reports lost records.

---
 rtl/uart_result_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_result_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// uart_result_tx: buffers memory-stage stores in a small FIFO and streams each
// one out as a 3-byte 8N1 UART record {addr, data[15:8], data[7:0]}.
// Writes are never back-pressured; a store arriving while the FIFO is full is
// dropped and flagged by a one-cycle overflow pulse.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [3:0]                    wr_addr,
    input  logic [15:0]                   wr_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and control
    logic [19:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              push;
    logic              pop;
    logic [19:0]       head;

    // Transmitter state
    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        shift_q;
    logic [15:0]       data_q;
    logic              tx_q;
    logic [7:0]        next_byte;

    // Fullness is judged on the registered count, so a pop on the same edge
    // never rescues a write that arrives while full.
    assign fifo_full = (count_q == DEPTH_C);
    assign push      = wr_en & ~fifo_full;
    assign pop       = (state_q == IDLE) & (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign next_byte = (byte_idx_q == 2'd0) ? data_q[15:8] : data_q[7:0];

    // Occupancy update: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and the registered overflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= wr_en & fifo_full;
        end
    end

    // Record storage; contents need no reset because the pointers gate access.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
    end

    // UART framing FSM: baud counter restarts on every state entry so each
    // bit lasts exactly CLKS_PER_BIT cycles; STOP chains straight into the
    // next START within a record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (pop) begin
                        data_q     <= head[15:0];
                        shift_q    <= {4'h0, head[19:16]};
                        byte_idx_q <= 2'd0;
                        bit_idx_q  <= 3'd0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (byte_idx_q != 2'd2) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            shift_q    <= next_byte;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_uart_result_tx.sv
// Self-checking bench for uart_result_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_result_tx;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_result_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic [23:0] exp_bytes;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for a start bit, then samples 120 cycles at negedges and
    // decodes three 8N1 bytes, requiring every bit to hold for 4 samples.
    task automatic capture(output logic [23:0] bytes, output logic ok,
                           output int t_fall, output int waited, output logic busy_all);
        logic s[120];
        int base;
        bytes = '0; ok = 1'b0; t_fall = 0; waited = 0; busy_all = 1'b1;
        while (tx !== 1'b0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) return;
        t_fall = cyc;
        s[0] = tx;
        busy_all = busy_all & busy;
        for (int i = 1; i < 120; i++) begin
            @(negedge clk);
            s[i] = tx;
            busy_all = busy_all & busy;
        end
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 10; j++) begin
                base = (k * 10 + j) * 4;
                for (int c = 1; c < 4; c++)
                    if (s[base + c] !== s[base]) ok = 1'b0;
                if (j == 0 && s[base] !== 1'b0) ok = 1'b0;
                if (j == 9 && s[base] !== 1'b1) ok = 1'b0;
                if (j >= 1 && j <= 8) bytes[(2 - k) * 8 + (j - 1)] = s[base];
            end
        end
    endtask

    initial begin
        logic [23:0] bytes;
        logic        ok;
        logic        busy_all;
        logic        quiet;
        int          tf;
        int          w;
        logic [23:0] rec_bytes[5];
        logic        rec_ok[5];
        int          rec_t[5];
        int          exp_cnt[7];
        logic        exp_ov[7];

        vecs[0] = '{4'h3, 16'hA55A, 24'h03A55A};
        vecs[1] = '{4'hF, 16'h00FF, 24'h0F00FF};
        vecs[2] = '{4'h0, 16'h0000, 24'h000000};
        vecs[3] = '{4'hA, 16'h1234, 24'h0A1234};
        vecs[4] = '{4'h5, 16'h8001, 24'h058001};
        exp_cnt = '{1, 1, 2, 3, 4, 4, 4};
        exp_ov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_tx", tx, 1);

        // Single records from the vector table
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            wr_addr = vecs[v].addr; wr_data = vecs[v].data; wr_en = 1'b1;
            @(negedge clk);
            wr_en = 1'b0;
            chk($sformatf("v%0d_tx_before_fall", v), tx, 1);
            chk($sformatf("v%0d_busy_accept", v), busy, 1);
            capture(bytes, ok, tf, w, busy_all);
            chk($sformatf("v%0d_latency", v), w, 1);
            chk($sformatf("v%0d_frame", v), ok, 1);
            chk($sformatf("v%0d_bytes", v), bytes, vecs[v].exp_bytes);
            chk($sformatf("v%0d_busy_during", v), busy_all, 1);
            @(negedge clk);
            chk($sformatf("v%0d_end_tx", v), tx, 1);
            chk($sformatf("v%0d_end_busy", v), busy, 0);
        end

        // Six stores back to back: fifth fills the FIFO, sixth overflows
        fork
            begin
                @(negedge clk);
                wr_addr = 4'd0; wr_data = 16'h1000; wr_en = 1'b1;
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    chk($sformatf("ovf_count%0d", i), fifo_count, exp_cnt[i]);
                    chk($sformatf("ovf_pulse%0d", i), overflow, exp_ov[i]);
                    if (i == 4 || i == 5) chk($sformatf("ovf_full%0d", i), fifo_full, 1);
                    if (i < 5) begin
                        wr_addr = 4'(i + 1); wr_data = 16'h1000 + 16'(i + 1);
                    end else begin
                        wr_en = 1'b0;
                    end
                end
            end
            begin
                for (int r = 0; r < 5; r++)
                    capture(rec_bytes[r], rec_ok[r], rec_t[r], w, busy_all);
            end
        join
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("ovf_rec%0d_frame", r), rec_ok[r], 1);
            chk($sformatf("ovf_rec%0d_bytes", r), rec_bytes[r], {4'h0, 4'(r), 8'h10, 8'(r)});
            if (r > 0) chk($sformatf("ovf_rec%0d_spacing", r), rec_t[r] - rec_t[r-1], 121);
        end
        quiet = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("ovf_no_sixth", quiet, 1);

        // Push on the same edge that pops the remaining entry
        fork
            begin
                @(negedge clk);
                wr_addr = 4'd6; wr_data = 16'hBEEF; wr_en = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
                w = 0;
                while (tx !== 1'b0 && w < 10) begin
                    @(negedge clk);
                    w++;
                end
                chk("pp_fall", tx, 0);
                repeat (2) @(negedge clk);
                wr_addr = 4'd7; wr_data = 16'h0102; wr_en = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
                chk("pp_count_b", fifo_count, 1);
                repeat (117) @(negedge clk);
                chk("pp_pre_count", fifo_count, 1);
                chk("pp_pre_tx", tx, 1);
                wr_addr = 4'd8; wr_data = 16'hC3C3; wr_en = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
                chk("pp_count", fifo_count, 1);
                chk("pp_ovf", overflow, 0);
                chk("pp_next_start", tx, 0);
            end
            begin
                for (int r = 0; r < 3; r++)
                    capture(rec_bytes[r], rec_ok[r], rec_t[r], w, busy_all);
            end
        join
        chk("pp_a_bytes", rec_bytes[0], 24'h06BEEF);
        chk("pp_b_bytes", rec_bytes[1], 24'h070102);
        chk("pp_c_bytes", rec_bytes[2], 24'h08C3C3);
        chk("pp_frames", {rec_ok[0], rec_ok[1], rec_ok[2]}, 3'b111);
        chk("pp_spacing_ab", rec_t[1] - rec_t[0], 121);
        chk("pp_spacing_bc", rec_t[2] - rec_t[1], 121);
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of byte1 with two records queued
        wr_addr = 4'd9; wr_data = 16'h00F0; wr_en = 1'b1;
        @(negedge clk);
        wr_addr = 4'd1; wr_data = 16'h1111;
        @(negedge clk);
        wr_addr = 4'd2; wr_data = 16'h2222;
        @(negedge clk);
        wr_en = 1'b0;
        chk("mr_queued", fifo_count, 2);
        repeat (48) @(negedge clk);
        chk("mr_pre_tx", tx, 0);
        #2 reset = 1'b1;
        #1;
        chk("mr_tx", tx, 1);
        chk("mr_count", fifo_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_full", fifo_full, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("mr_quiet", quiet, 1);
        wr_addr = 4'hC; wr_data = 16'h5AA5; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        capture(bytes, ok, tf, w, busy_all);
        chk("mr_after_latency", w, 1);
        chk("mr_after_frame", ok, 1);
        chk("mr_after_bytes", bytes, 24'h0C5AA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
